// File: rtl/fetch_pc_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_pc_queue_if : producer/consumer signal bundle for fetch_pc_queue
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fetch_pc_queue_if #(
  parameter int D_WIDTH = 32,
  parameter int PHT_AW  = 8,
  parameter int CW      = 3
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [D_WIDTH-1:0]   in_pc;
  logic [1:0]           in_pc_src;
  logic [D_WIDTH-1:0]   in_target_btb;
  logic                 in_predict;
  logic [PHT_AW-1:0]    in_addr_pht;
  logic                 out_valid;
  logic                 out_ready;
  logic [D_WIDTH-1:0]   out_pc;
  logic [1:0]           out_pc_src;
  logic [D_WIDTH-1:0]   out_target_btb;
  logic                 out_predict;
  logic [PHT_AW-1:0]    out_addr_pht;
  logic [CW-1:0]        count;

  modport master (
    output flush, in_valid, in_pc, in_pc_src, in_target_btb, in_predict,
           in_addr_pht, out_ready,
    input  in_ready, out_valid, out_pc, out_pc_src, out_target_btb,
           out_predict, out_addr_pht, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_pc_src, in_target_btb, in_predict,
           in_addr_pht, out_ready,
    output in_ready, out_valid, out_pc, out_pc_src, out_target_btb,
           out_predict, out_addr_pht, count
  );
endinterface

`default_nettype wire

// File: rtl/fetch_pc_queue.sv
// ---------------------------------------------------------------------------
// fetch_pc_queue : first-word-fall-through queue of fetch PCs and prediction data
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_pc_queue #(
  parameter int D_WIDTH = 32,
  parameter int DEPTH   = 4,
  parameter int PHT_AW  = 8,
  parameter int CW      = $clog2(DEPTH) + 1
) (
  input  wire logic       clk,
  input  wire logic       rst,
  fetch_pc_queue_if.slave q
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 2*D_WIDTH + PHT_AW + 3;

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = q.in_valid && !w_full;
  assign w_pop   = q.out_ready && !w_empty;

  // in_ready is held low during reset so nothing is offered before the queue is live
  assign q.in_ready  = !rst && !w_full;
  assign q.out_valid = !w_empty;
  assign q.count     = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (q.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Storage carries no reset; invalid slots are masked at the output
  always_ff @(posedge clk) begin
    if (w_push && !q.flush && !rst)
      r_mem[r_wr_ptr] <= {q.in_pc, q.in_pc_src, q.in_target_btb,
                          q.in_predict, q.in_addr_pht};
  end

  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];
  assign {q.out_pc, q.out_pc_src, q.out_target_btb,
          q.out_predict, q.out_addr_pht} = w_head;

endmodule

`default_nettype wire
